// File: rtl/sort_window_feeder_if.sv
// Handshake bundle between the upstream sample source, the window feeder and
// the downstream compare-and-swap sorter.
//   in_valid/in_ready/in_data/in_last : sample stream into the feeder
//   win_valid/win_ready/win_data      : window stream out of the feeder
//   drop                              : pulse when a partial window is discarded
// slave  : the feeder's view
// master : the environment's view (source + sorter)
interface sort_window_feeder_if #(
    parameter int NUM_INPUTS = 3,
    parameter int WIDTH      = 3
);
    logic                        in_valid;
    logic                        in_ready;
    logic [WIDTH-1:0]            in_data;
    logic                        in_last;
    logic                        win_valid;
    logic                        win_ready;
    logic [NUM_INPUTS*WIDTH-1:0] win_data;
    logic                        drop;

    modport slave (
        input  in_valid, in_data, in_last, win_ready,
        output in_ready, win_valid, win_data, drop
    );

    modport master (
        output in_valid, in_data, in_last, win_ready,
        input  in_ready, win_valid, win_data, drop
    );
endinterface

// File: rtl/sort_window_feeder.sv
// Sliding-window feeder for a downstream compare-and-swap sorter.
// Accepted samples shift into a NUM_INPUTS-deep window (slot 0 newest); a
// window is emitted when the window first fills and then every STRIDE accepts.
// in_last ends a segment: the window restarts empty, and a segment too short
// to fill a window is reported with a one-cycle drop pulse.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : sort_window_feeder_if.slave (sample in, window out, drop)
module sort_window_feeder #(
    parameter int NUM_INPUTS = 3,
    parameter int WIDTH      = 3,
    parameter int STRIDE     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    sort_window_feeder_if.slave   bus
);

    localparam int CW = $clog2(NUM_INPUTS + 1);
    localparam int WW = NUM_INPUTS * WIDTH;
    localparam int HW = (NUM_INPUTS - 1) * WIDTH;

    typedef enum logic {
        FILL,
        FULL
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   fill_q, fill_d;
    logic [CW-1:0]   stride_q, stride_d;
    // Only the newest NUM_INPUTS-1 samples are kept: the oldest slot always
    // falls out on the next shift, and the emitted copy lives in win_data_q.
    logic [HW-1:0]   hist_q, hist_d;
    logic [WW-1:0]   win_data_q, win_data_d;
    logic            win_valid_q, win_valid_d;
    logic            drop_q, drop_d;

    logic            accept;
    logic            emit;
    logic [WW-1:0]   shifted;
    logic [CW-1:0]   fill_inc;
    logic [CW-1:0]   stride_inc;

    assign bus.in_ready  = !win_valid_q || bus.win_ready;
    assign bus.win_valid = win_valid_q;
    assign bus.win_data  = win_data_q;
    assign bus.drop      = drop_q;

    assign accept     = bus.in_valid && bus.in_ready;
    assign shifted    = {hist_q, bus.in_data};
    assign fill_inc   = fill_q + 1'b1;
    assign stride_inc = stride_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            fill_q      <= '0;
            stride_q    <= '0;
            hist_q      <= '0;
            win_data_q  <= '0;
            win_valid_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            stride_q    <= stride_d;
            hist_q      <= hist_d;
            win_data_q  <= win_data_d;
            win_valid_q <= win_valid_d;
            drop_q      <= drop_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        stride_d    = stride_q;
        hist_d      = hist_q;
        win_data_d  = win_data_q;
        win_valid_d = win_valid_q;
        drop_d      = 1'b0;
        emit        = 1'b0;

        if (win_valid_q && bus.win_ready) begin
            win_valid_d = 1'b0;
        end

        if (accept) begin
            hist_d = shifted[HW-1:0];
            if (state_q == FILL) begin
                fill_d = fill_inc;
                if (fill_inc == CW'(NUM_INPUTS)) begin
                    emit    = 1'b1;
                    state_d = FULL;
                end
            end else begin
                if (stride_inc == CW'(STRIDE)) begin
                    emit     = 1'b1;
                    stride_d = '0;
                end else begin
                    stride_d = stride_inc;
                end
            end

            // A coinciding handoff is overridden here, so win_valid stays high.
            if (emit) begin
                win_valid_d = 1'b1;
                win_data_d  = shifted;
            end

            // Segment end is applied after the emission decision above.
            if (bus.in_last) begin
                drop_d   = !emit && (state_q == FILL);
                state_d  = FILL;
                fill_d   = '0;
                stride_d = '0;
                hist_d   = '0;
            end
        end
    end

endmodule

// File: doc/sort_window_feeder.md
SORT_WINDOW_FEEDER -- requirements
Module: sort_window_feeder

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 3, window size in samples; legal range 2..5.
REQ-002 SHALL have parameter WIDTH, default 3, bit width of each sample.
REQ-003 SHALL have parameter STRIDE, default 1, accepted samples between successive windows; legal range 1..NUM_INPUTS.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1, in_data holds a sample.
REQ-007 SHALL have port in_ready, output, 1, the block can accept a sample this cycle.
REQ-008 SHALL have port in_data, input, WIDTH, sample value, unsigned.
REQ-009 SHALL have port in_last, input, 1, the accepted sample ends the current stream segment.
REQ-010 SHALL have port win_valid, output, 1, win_data holds a complete window.
REQ-011 SHALL have port win_ready, input, 1, the downstream compare-and-swap sorter consumes the window.
REQ-012 SHALL have port win_data, output, NUM_INPUTS*WIDTH, window; slot i is bits [i*WIDTH +: WIDTH]; slot 0 is the newest sample and slot NUM_INPUTS-1 the oldest.
REQ-013 SHALL have port drop, output, 1, one-cycle pulse when a partial window is discarded.

Function
REQ-014 SHALL accept a sample exactly when in_valid && in_ready; acceptance shifts in_data into slot 0 and moves each slot k to slot k+1, dropping the oldest sample.
REQ-015 SHALL drive in_ready = !win_valid || win_ready (combinational; no skid buffer).
REQ-016 SHALL keep a fill counter, 0..NUM_INPUTS, that increments on each accept and saturates at NUM_INPUTS.
REQ-017 SHALL implement the states FILL (fill < NUM_INPUTS) and FULL (fill == NUM_INPUTS).
- FILL -> FULL on the accept that makes fill reach NUM_INPUTS.
- FULL -> FILL only on in_last or rst.
REQ-018 SHALL keep a stride counter that counts accepts in FULL since the last emission; it is cleared on every emission.
REQ-019 SHALL emit a window on an accept when either condition holds; on emission the post-shift window is loaded into the win_data register and win_valid = 1 on the next cycle, giving 1-cycle latency from accept to win_valid.
- The accept causes FILL -> FULL.
- The state is already FULL and the stride count after this accept equals STRIDE.
REQ-020 SHALL hold win_data and win_valid stable while win_valid && !win_ready.
REQ-021 SHALL clear win_valid when win_ready is high and no emission occurs in the same cycle; when handoff and a new emission coincide, win_valid SHALL stay 1 with the new data.
REQ-022 SHALL handle an accepted in_last sample in this order:
- first apply the normal emission rule for that sample;
- then clear fill, stride and all window slots to 0 and return to FILL.
REQ-023 SHALL, if in_last is accepted while fill after the accept is < NUM_INPUTS, emit nothing and pulse drop for exactly one cycle, one cycle after the accept.
REQ-024 SHALL ignore in_data and in_last when no accept occurs.
REQ-025 SHALL never reorder samples; sorting is done by the downstream CAS stage.

Reset
REQ-026 SHALL, while rst is high at a clock edge, set the following, regardless of handshakes in progress:
- win_valid = 0, drop = 0, win_data = 0;
- fill = 0, stride = 0, all slots 0;
- state FILL.
REQ-027 SHALL drive in_ready = 1 in the first cycle after rst deasserts.
REQ-028 SHALL discard any window pending at reset without it being observed as valid.

Verification (NUM_INPUTS=3, WIDTH=3 unless noted)
REQ-029 SHALL cover first fill at STRIDE=1.
- Stimulus: accept 5, 2, 7 with win_ready=1.
- Response: one cycle after the third accept, win_valid=1 and slots {0,1,2}={7,2,5}.
- Stimulus: then accept 1.
- Response: next window {1,7,2}.
REQ-030 SHALL cover backpressure.
- Stimulus: hold win_ready=0 after the first window.
- Response: in_ready=0, win_data frozen at {7,2,5}, no sample lost.
- Stimulus: raise win_ready.
- Response: window consumed, in_ready=1 in that same cycle.
REQ-031 SHALL cover STRIDE=3.
- Stimulus: accept 1..9.
- Response: exactly three windows, {3,2,1}, {6,5,4} and {1,0,7}; the third is the 3-bit wrap of 9,8,7.
REQ-032 SHALL cover a partial segment.
- Stimulus: accept 4, then 6 with in_last.
- Response: no win_valid, drop pulses once.
- Stimulus: then accept 1, 2, 3.
- Response: window {3,2,1}, with no stale 4 or 6.
REQ-033 SHALL cover in_last on a full window.
- Stimulus: accept 1, 2, 3(last).
- Response: window {3,2,1}.
- Stimulus: the next three accepts.
- Response: needed before any further window.
REQ-034 SHALL cover mid-operation reset.
- Stimulus: assert rst for 1 cycle with win_valid=1 and fill=3.
- Response: next cycle win_valid=0, in_ready=1.
- Response: 3 new accepts are needed before the next window.
